// File: rtl/seat_access_arbiter.sv
// Seat-record memory arbiter: round-robin kiosk grant, validate, commit.
// Optional wipe path enabled by defining SEAT_CLEAR_EN.
module seat_access_arbiter #(
    parameter int NUM_KIOSK = 4,
    parameter int NUM_SEATS = 32,
    parameter int TIME_W    = 11
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tick_min,
    input  logic [NUM_KIOSK-1:0]   req,
    input  logic [32*NUM_KIOSK-1:0] k_student_no,
    input  logic [5*NUM_KIOSK-1:0] k_seat_no,
    input  logic [2*NUM_KIOSK-1:0] k_seat_state,
    output logic [NUM_KIOSK-1:0]   ack,
    output logic [1:0]             result,
    output logic                   busy,
    output logic [TIME_W-1:0]      time_now,
    input  logic                   clear_req,
    output logic                   clear_done,
    output logic                   write_mem,
    output logic [31:0]            Student_No_mem,
    output logic [TIME_W-1:0]      Time_mem,
    output logic [1:0]             Seat_State_mem,
    output logic [4:0]             Seat_No_mem,
    output logic                   rst_mem,
    input  logic                   Do_Not_Seat
);

    localparam int PW = (NUM_KIOSK > 1) ? $clog2(NUM_KIOSK) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        CHECK,
        COMMIT,
        RESP
    } state_t;

    state_t          state;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   gnt;
    logic            bad;

    logic            gnt_vld;
    logic [PW-1:0]   gnt_idx;
    logic [PW-1:0]   cand;
    logic [31:0]     sel_stu;
    logic [4:0]      sel_seat;
    logic [1:0]      sel_state;

    // First requester at or after rr_ptr, plus that kiosk's fields
    always_comb begin
        gnt_vld   = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        sel_stu   = '0;
        sel_seat  = '0;
        sel_state = '0;
        for (int k = NUM_KIOSK - 1; k >= 0; k--) begin
            cand = PW'((int'(rr_ptr) + k) % NUM_KIOSK);
            if (req[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
        for (int i = 0; i < NUM_KIOSK; i++) begin
            if (int'(gnt_idx) == i) begin
                sel_stu   = k_student_no[32*i +: 32];
                sel_seat  = k_seat_no[5*i +: 5];
                sel_state = k_seat_state[2*i +: 2];
            end
        end
    end

    // Free-running minute counter, independent of the FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            time_now <= '0;
        end else if (tick_min) begin
            time_now <= time_now + TIME_W'(1);
        end
    end

    // Transaction sequencer with registered memory and kiosk outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            gnt            <= '0;
            bad            <= 1'b0;
            ack            <= '0;
            result         <= 2'b00;
            busy           <= 1'b0;
            write_mem      <= 1'b0;
            Student_No_mem <= '0;
            Time_mem       <= '0;
            Seat_State_mem <= '0;
            Seat_No_mem    <= '0;
`ifdef SEAT_CLEAR_EN
            rst_mem        <= 1'b0;
            clear_done     <= 1'b0;
`endif
        end else begin
            write_mem <= 1'b0;
            ack       <= '0;
`ifdef SEAT_CLEAR_EN
            rst_mem    <= 1'b0;
            clear_done <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
`ifdef SEAT_CLEAR_EN
                    if (clear_req) begin
                        rst_mem    <= 1'b1;
                        clear_done <= 1'b1;
                    end else if (gnt_vld) begin
`else
                    if (gnt_vld) begin
`endif
                        gnt            <= gnt_idx;
                        rr_ptr         <= PW'((int'(gnt_idx) + 1) % NUM_KIOSK);
                        Student_No_mem <= sel_stu;
                        Seat_No_mem    <= sel_seat;
                        Seat_State_mem <= sel_state;
                        Time_mem       <= time_now;
                        busy           <= 1'b1;
                        state          <= SETUP;
                    end
                end
                SETUP: begin
                    bad   <= (int'(Seat_No_mem) >= NUM_SEATS) ||
                             (Seat_State_mem == 2'd2);
                    state <= CHECK;
                end
                CHECK: begin
                    if (bad) begin
                        result <= 2'b10;
                    end else if (Do_Not_Seat) begin
                        result <= 2'b01;
                    end else begin
                        result <= 2'b00;
                    end
                    write_mem <= !bad && !Do_Not_Seat;
                    state     <= COMMIT;
                end
                COMMIT: begin
                    ack   <= NUM_KIOSK'(1) << gnt;
                    state <= RESP;
                end
                RESP: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifndef SEAT_CLEAR_EN
    logic unused_clear_req;
    assign unused_clear_req = clear_req;
    assign clear_done = 1'b0;

    // Memory seat states follow system reset one cycle late
    always_ff @(posedge clk) begin
        rst_mem <= rst;
    end
`endif

endmodule

// File: tb/tb_seat_access_arbiter.sv
// Randomized bench for seat_access_arbiter against a transaction-level model.
// Also exercises the SEAT_CLEAR_EN wipe path when that macro is defined.
module tb_seat_access_arbiter;

    localparam int NK = 4;
    localparam int NS = 24;
    localparam int TW = 11;

    logic              clk = 1'b0;
    logic              rst;
    logic              tick_min;
    logic [NK-1:0]     req;
    logic [32*NK-1:0]  k_student_no;
    logic [5*NK-1:0]   k_seat_no;
    logic [2*NK-1:0]   k_seat_state;
    logic [NK-1:0]     ack;
    logic [1:0]        result;
    logic              busy;
    logic [TW-1:0]     time_now;
    logic              clear_req;
    logic              clear_done;
    logic              write_mem;
    logic [31:0]       Student_No_mem;
    logic [TW-1:0]     Time_mem;
    logic [1:0]        Seat_State_mem;
    logic [4:0]        Seat_No_mem;
    logic              rst_mem;
    logic              Do_Not_Seat;

    logic [31:0] kst[NK];
    logic [4:0]  kse[NK];
    logic [1:0]  kss[NK];

    logic [1:0] mem[32] = '{default: 2'd0};

    int n_chk = 0;
    int n_bad = 0;
    int cyc   = 0;

    seat_access_arbiter #(
        .NUM_KIOSK(NK),
        .NUM_SEATS(NS),
        .TIME_W(TW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tick_min(tick_min),
        .req(req),
        .k_student_no(k_student_no),
        .k_seat_no(k_seat_no),
        .k_seat_state(k_seat_state),
        .ack(ack),
        .result(result),
        .busy(busy),
        .time_now(time_now),
        .clear_req(clear_req),
        .clear_done(clear_done),
        .write_mem(write_mem),
        .Student_No_mem(Student_No_mem),
        .Time_mem(Time_mem),
        .Seat_State_mem(Seat_State_mem),
        .Seat_No_mem(Seat_No_mem),
        .rst_mem(rst_mem),
        .Do_Not_Seat(Do_Not_Seat)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NK; i++) begin
            k_student_no[32*i +: 32] = kst[i];
            k_seat_no[5*i +: 5]      = kse[i];
            k_seat_state[2*i +: 2]   = kss[i];
        end
    end

    // Seat memory: occupancy flag and write/wipe behaviour
    assign Do_Not_Seat = (mem[Seat_No_mem] == 2'd3) && (Seat_State_mem == 2'd3);

    always @(posedge clk) begin
        if (rst_mem) begin
            for (int i = 0; i < 32; i++) mem[i] <= 2'd0;
        end else if (write_mem) begin
            mem[Seat_No_mem] <= Seat_State_mem;
        end
    end

    // ---------------- reference model ----------------
    int          m_time, m_ptr, m_phase, m_k, m_res;
    int          m_seat, m_state, m_stamp;
    logic [31:0] m_stu;
    int          seat_tab[32];
    logic [NK-1:0] e_ack;
    logic        e_wr, e_busy, e_rstmem, e_cdone;

    logic          s_rst, s_tick, s_clr;
    logic [NK-1:0] s_req;
    logic [31:0]   s_stu[NK];
    logic [4:0]    s_se[NK];
    logic [1:0]    s_ss[NK];

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_update();
        bit clr_en;
`ifdef SEAT_CLEAR_EN
        clr_en = 1'b1;
`else
        clr_en = 1'b0;
`endif
        e_rstmem = 1'b0;
        e_cdone  = 1'b0;
        if (s_rst) begin
            m_time = 0; m_ptr = 0; m_phase = 0; m_k = 0; m_res = 0;
            m_seat = 0; m_state = 0; m_stamp = 0; m_stu = '0;
            if (!clr_en) begin
                e_rstmem = 1'b1;
                for (int i = 0; i < 32; i++) seat_tab[i] = 0;
            end
        end else begin
            if (m_phase != 0) begin
                m_phase = (m_phase == 4) ? 0 : m_phase + 1;
                if (m_phase == 3 && m_res == 0) seat_tab[m_seat] = m_state;
            end else if (clr_en && s_clr) begin
                e_rstmem = 1'b1;
                e_cdone  = 1'b1;
                for (int i = 0; i < 32; i++) seat_tab[i] = 0;
            end else begin
                for (int k = 0; k < NK; k++) begin
                    int i;
                    i = (m_ptr + k) % NK;
                    if (m_phase == 0 && s_req[i]) begin
                        m_k     = i;
                        m_seat  = int'(s_se[i]);
                        m_state = int'(s_ss[i]);
                        m_stu   = s_stu[i];
                        m_stamp = m_time;
                        m_ptr   = (i + 1) % NK;
                        m_phase = 1;
                        if (m_seat >= NS || m_state == 2) m_res = 2;
                        else if (seat_tab[m_seat] == 3 && m_state == 3) m_res = 1;
                        else m_res = 0;
                    end
                end
            end
            if (s_tick) m_time = (m_time + 1) % (1 << TW);
        end
        e_busy = (m_phase != 0);
        e_wr   = (m_phase == 3) && (m_res == 0);
        e_ack  = (m_phase == 4) ? NK'(1) << m_k : '0;
    endtask

    task automatic check_all();
        chk("ack", ack, e_ack);
        chk("write_mem", write_mem, e_wr);
        chk("busy", busy, e_busy);
        chk("time_now", time_now, m_time);
        chk("seat_no", Seat_No_mem, m_seat);
        chk("seat_state", Seat_State_mem, m_state);
        chk("student", Student_No_mem, m_stu);
        chk("stamp", Time_mem, m_stamp);
        chk("rst_mem", rst_mem, e_rstmem);
        chk("clear_done", clear_done, e_cdone);
        if (e_ack != '0) chk("result", result, m_res);
    endtask

    task automatic step();
        s_rst  = rst;
        s_tick = tick_min;
        s_clr  = clear_req;
        s_req  = req;
        for (int i = 0; i < NK; i++) begin
            s_stu[i] = kst[i];
            s_se[i]  = kse[i];
            s_ss[i]  = kss[i];
        end
        @(posedge clk);
        #1;
        cyc++;
        model_update();
        check_all();
    endtask

    task automatic new_fields(input int i);
        int r;
        if ($urandom_range(0, 2) == 0) begin
            r = $urandom_range(0, 3);
            kse[i] = (r == 0) ? 5'd9 : (r == 1) ? 5'd5 : (r == 2) ? 5'd23 : 5'd24;
        end else begin
            kse[i] = 5'($urandom_range(0, 31));
        end
        r = $urandom_range(0, 9);
        kss[i] = (r < 4) ? 2'd3 : (r < 6) ? 2'd1 : (r < 8) ? 2'd0 : 2'd2;
        kst[i] = $urandom;
    endtask

    // Kiosks hold until acked; then drop or re-request with fresh fields
    task automatic kiosk_update(input int prob, input bit rerq);
        for (int i = 0; i < NK; i++) begin
            if (e_ack[i]) begin
                if (rerq) new_fields(i);
                else req[i] = 1'b0;
            end else if (!req[i] && prob > 0 && $urandom_range(0, 99) < prob) begin
                req[i] = 1'b1;
                new_fields(i);
            end
        end
    endtask

    task automatic do_one(input int k, input int seat, input int st,
                          input logic [31:0] stu, output int res, output bit wr);
        bit got;
        kst[k] = stu;
        kse[k] = 5'(seat);
        kss[k] = 2'(st);
        req[k] = 1'b1;
        got = 1'b0;
        wr  = 1'b0;
        res = -1;
        for (int n = 0; n < 20 && !got; n++) begin
            step();
            if (write_mem) wr = 1'b1;
            if (ack[k]) begin
                got = 1'b1;
                res = int'(result);
            end
            kiosk_update(0, 1'b0);
        end
        req[k] = 1'b0;
        chk("txn_ack_seen", got, 1);
        step();
    endtask

    int ack_q[$];
    int cyc_q[$];
    int res;
    bit wr;
    int n_ack, n_wr;

    initial begin
        rst = 1'b1; tick_min = 1'b0; clear_req = 1'b0; req = '0;
        for (int i = 0; i < NK; i++) begin
            kst[i] = '0; kse[i] = '0; kss[i] = '0;
        end
        for (int i = 0; i < 32; i++) seat_tab[i] = 0;
        repeat (3) step();
        chk("reset_time", time_now, 0);
        chk("reset_busy", busy, 0);
        chk("reset_ack", ack, 0);
        chk("reset_result", result, 0);
        chk("reset_write", write_mem, 0);
        rst = 1'b0;
        step();

        // single request at time 7
        tick_min = 1'b1;
        repeat (7) step();
        tick_min = 1'b0;
        chk("time_seven", time_now, 7);
        kst[2] = 32'h1234; kse[2] = 5'd5; kss[2] = 2'd1; req[2] = 1'b1;
        step();
        chk("single_busy", busy, 1);
        step();
        step();
        chk("single_wr", write_mem, 1);
        chk("single_seat", Seat_No_mem, 5);
        chk("single_time", Time_mem, 7);
        chk("single_state", Seat_State_mem, 1);
        chk("single_stu", Student_No_mem, 32'h1234);
        step();
        chk("single_ack", ack, 4'b0100);
        chk("single_res", result, 0);
        kiosk_update(0, 1'b0);
        step();
        chk("single_idle", busy, 0);

        // round robin with all kiosks hammering
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < NK; i++) begin
            kst[i] = 32'(i); kse[i] = 5'(i + 1); kss[i] = 2'd1;
        end
        req = '1;
        for (int n = 0; n < 30; n++) begin
            step();
            for (int i = 0; i < NK; i++) begin
                if (ack[i]) begin
                    ack_q.push_back(i);
                    cyc_q.push_back(cyc);
                end
            end
            kiosk_update(0, 1'b1);
        end
        req = '0;
        repeat (6) step();
        chk("rr_count", (ack_q.size() >= 5), 1);
        if (ack_q.size() >= 5) begin
            for (int j = 0; j < 5; j++) begin
                chk("rr_order", ack_q[j], j % NK);
                if (j > 0) chk("rr_gap", cyc_q[j] - cyc_q[j-1], 5);
            end
        end

        // occupied seat
        do_one(1, 9, 0, 32'hA1, res, wr);
        chk("occ_free_res", res, 0);
        do_one(1, 9, 3, 32'hA2, res, wr);
        chk("occ_take_res", res, 0);
        chk("occ_take_wr", wr, 1);
        do_one(2, 9, 3, 32'hA3, res, wr);
        chk("occ_res", res, 1);
        chk("occ_wr", wr, 0);

        // bad arguments and seat boundary
        do_one(0, NS, 1, 32'hB1, res, wr);
        chk("bad_seat_res", res, 2);
        chk("bad_seat_wr", wr, 0);
        do_one(0, NS - 1, 1, 32'hB2, res, wr);
        chk("last_seat_res", res, 0);
        chk("last_seat_wr", wr, 1);
        do_one(3, 5, 2, 32'hB3, res, wr);
        chk("bad_state_res", res, 2);
        chk("bad_state_wr", wr, 0);

        // clear request racing a kiosk request
        kst[0] = 32'hC0; kse[0] = 5'd9; kss[0] = 2'd3;
        req[0] = 1'b1;
        clear_req = 1'b1;
        step();
`ifdef SEAT_CLEAR_EN
        chk("clr_rst_mem", rst_mem, 1);
        chk("clr_done", clear_done, 1);
        chk("clr_idle", busy, 0);
        clear_req = 1'b0;
        step();
        chk("clr_then_grant", busy, 1);
`else
        chk("noclr_done", clear_done, 0);
        chk("noclr_rst_mem", rst_mem, 0);
        chk("noclr_grant", busy, 1);
        clear_req = 1'b0;
`endif
        res = -1;
        for (int n = 0; n < 10; n++) begin
            step();
            if (ack[0]) res = int'(result);
            kiosk_update(0, 1'b0);
        end
`ifdef SEAT_CLEAR_EN
        chk("clr_wiped_res", res, 0);
`else
        chk("noclr_occ_res", res, 1);
`endif

        // reset while in CHECK
        kst[3] = 32'hD0; kse[3] = 5'd7; kss[3] = 2'd1; req[3] = 1'b1;
        step();
        step();
        rst = 1'b1;
        req = '0;
        step();
        rst = 1'b0;
        n_ack = 0;
        n_wr  = 0;
        for (int n = 0; n < 8; n++) begin
            step();
            if (ack != '0) n_ack++;
            if (write_mem) n_wr++;
        end
        chk("rstmid_ack", n_ack, 0);
        chk("rstmid_wr", n_wr, 0);
        chk("rstmid_idle", busy, 0);

        // minute counter wrap
        tick_min = 1'b1;
        repeat (2047) step();
        chk("time_max", time_now, 2047);
        step();
        tick_min = 1'b0;
        chk("time_wrap", time_now, 0);

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            tick_min  = ($urandom_range(0, 3) == 0);
            clear_req = ($urandom_range(0, 40) == 0);
            rst       = ($urandom_range(0, 300) == 0);
            step();
            kiosk_update(25, 1'($urandom_range(0, 1)));
        end
        rst = 1'b0; tick_min = 1'b0; clear_req = 1'b0;
        for (int n = 0; n < 12; n++) begin
            step();
            kiosk_update(0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
